// File: rtl/pe_array_ctrl_pkg.sv
// pe_array_ctrl_pkg: shared FSM state encoding and datapath select constants
package pe_array_ctrl_pkg;
    typedef enum logic [2:0] {IDLE, WLOAD, STREAM, DRAIN, DONE} state_e;
    localparam logic SEL_DUMMY = 1'b0;
    localparam logic SEL_BUFF  = 1'b1;
endpackage

// File: rtl/tc_counter.sv
// tc_counter: clearable up-counter flagging the increment that reaches term
module tc_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] term,
    output logic         tc
);
    logic [W-1:0] q_q, q_d;
    assign tc = en && ((q_q + W'(1)) == term);
    // clear wins over increment
    always_comb q_d = clr ? '0 : q_q + W'(en);
    // count register
    always_ff @(posedge clk) begin
        if (!rst_n) q_q <= '0;
        else        q_q <= q_d;
    end
endmodule

// File: rtl/pe_array_data_in_ctrl.sv
// pe_array_data_in_ctrl: weight-load / activation-stream sequencer; PE_DATA_IN_CTRL_PERF_CNT_EN adds stall_cycles
module pe_array_data_in_ctrl import pe_array_ctrl_pkg::*; #(
    parameter int num_pe_row = 16,
    parameter int num_pe_col = 16,
    parameter int cnt_width  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [1:0]            cfg_row_shift,
    input  logic [cnt_width-1:0]  cfg_num_act_words,
    input  logic                  cfg_wload_en,
    input  logic                  cfg_use_dummy,
    input  logic                  wbuff_valid,
    output logic                  wbuff_rd_en,
    input  logic                  actbuff_valid,
    output logic                  actbuff_rd_en,
    input  logic [num_pe_row-1:0] pe_afifo_full,
    output logic                  pe_act_push,
    input  logic                  pe_array_idle,
    output logic [1:0]            compressed_act_in_sel,
    output logic                  last_row_shadow_afifo_in_sel,
    output logic                  wreg_in_sel,
    output logic                  busy,
    output logic                  done
`ifdef PE_DATA_IN_CTRL_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles
`endif
);
    localparam int BW = $clog2(num_pe_col + 1);
    state_e state_q, state_d;
    logic [1:0] shift_q, shift_d, sel_q, sel_d;
    logic [cnt_width-1:0] words_q, words_d;
    logic wload_q, wload_d, dummy_q, dummy_d, lrs_q, lrs_d, wreg_q, wreg_d;
    logic go, beat, wtc, atc, clr;
    assign go            = (state_q == IDLE) && start;
    assign beat          = (state_q == STREAM) && actbuff_valid && !(|pe_afifo_full);
    assign wbuff_rd_en   = (state_q == WLOAD) && wbuff_valid;
    assign actbuff_rd_en = beat;
    assign pe_act_push   = beat;
    assign busy          = state_q != IDLE;
    assign done          = state_q == DONE;
    assign clr           = (state_q == IDLE) || abort;
    assign compressed_act_in_sel        = sel_q;
    assign last_row_shadow_afifo_in_sel = lrs_q;
    assign wreg_in_sel                  = wreg_q;
    tc_counter #(.W(BW)) u_beat_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(wbuff_rd_en),
        .term(BW'(num_pe_col)), .tc(wtc)
    );
    tc_counter #(.W(cnt_width)) u_word_cnt (
        .clk(clk), .rst_n(rst_n), .clr(clr), .en(beat),
        .term(words_q), .tc(atc)
    );
    // next-state logic; abort overrides every transition
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = cfg_wload_en ? WLOAD : (|cfg_num_act_words) ? STREAM : DRAIN;
            WLOAD:   if (wtc) state_d = (|words_q) ? STREAM : DRAIN;
            STREAM:  if (atc) state_d = DRAIN;
            DRAIN:   if (pe_array_idle) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end
    // config latch and selects computed from the state being entered
    always_comb begin
        shift_d = abort ? '0 : go ? ((cfg_row_shift == 2'd0) ? 2'd1 : cfg_row_shift) : shift_q;
        words_d = abort ? '0 : go ? cfg_num_act_words : words_q;
        wload_d = abort ? 1'b0 : go ? cfg_wload_en : wload_q;
        dummy_d = abort ? 1'b0 : go ? cfg_use_dummy : dummy_q;
        wreg_d  = ((state_d != IDLE) && wload_d && !dummy_d) ? SEL_BUFF : SEL_DUMMY;
        lrs_d   = ((state_d == STREAM || state_d == DRAIN) && !dummy_d) ? SEL_BUFF : SEL_DUMMY;
        sel_d   = (lrs_d == SEL_BUFF) ? shift_d : 2'd0;
    end
    // state, config and select registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shift_q <= '0;
            words_q <= '0;
            wload_q <= 1'b0;
            dummy_q <= 1'b0;
            sel_q   <= '0;
            lrs_q   <= 1'b0;
            wreg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            words_q <= words_d;
            wload_q <= wload_d;
            dummy_q <= dummy_d;
            sel_q   <= sel_d;
            lrs_q   <= lrs_d;
            wreg_q  <= wreg_d;
        end
    end
`ifdef PE_DATA_IN_CTRL_PERF_CNT_EN
    logic [31:0] stall_q, stall_d;
    assign stall_cycles = stall_q;
    // saturating count of STREAM cycles without a beat, cleared on job start
    always_comb stall_d = go ? '0 : (state_q == STREAM && !beat && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
    // stall counter register
    always_ff @(posedge clk) begin
        if (!rst_n) stall_q <= '0;
        else        stall_q <= stall_d;
    end
`endif
endmodule

// File: tb/tb_pe_array_data_in_ctrl.sv
// tb_pe_array_data_in_ctrl: directed vectors plus multi-cycle job sequences
module tb_pe_array_data_in_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
    logic [1:0] cfg_row_shift = '0;
    logic [15:0] cfg_num_act_words = '0;
    logic cfg_wload_en = 1'b0, cfg_use_dummy = 1'b0;
    logic wbuff_valid = 1'b0, actbuff_valid = 1'b0, pe_array_idle = 1'b0;
    logic [15:0] pe_afifo_full = '0;
    logic wbuff_rd_en, actbuff_rd_en, pe_act_push, last_row_shadow_afifo_in_sel, wreg_in_sel, busy, done;
    logic [1:0] compressed_act_in_sel;
    logic [8:0] outs;
    int nvec = 0, nerr = 0;
`ifdef PE_DATA_IN_CTRL_PERF_CNT_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    pe_array_data_in_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_row_shift(cfg_row_shift), .cfg_num_act_words(cfg_num_act_words),
        .cfg_wload_en(cfg_wload_en), .cfg_use_dummy(cfg_use_dummy),
        .wbuff_valid(wbuff_valid), .wbuff_rd_en(wbuff_rd_en),
        .actbuff_valid(actbuff_valid), .actbuff_rd_en(actbuff_rd_en),
        .pe_afifo_full(pe_afifo_full), .pe_act_push(pe_act_push),
        .pe_array_idle(pe_array_idle), .compressed_act_in_sel(compressed_act_in_sel),
        .last_row_shadow_afifo_in_sel(last_row_shadow_afifo_in_sel),
        .wreg_in_sel(wreg_in_sel), .busy(busy), .done(done)
`ifdef PE_DATA_IN_CTRL_PERF_CNT_EN
        , .stall_cycles(stall_cycles)
`endif
    );

    assign outs = {busy, done, wbuff_rd_en, actbuff_rd_en, pe_act_push,
                   compressed_act_in_sel, last_row_shadow_afifo_in_sel, wreg_in_sel};

    typedef struct {
        logic        st, wl, dm;
        logic [1:0]  sh;
        logic [15:0] words;
        logic        wv, av;
        logic [15:0] full;
        logic        idle;
        logic [8:0]  exp;
    } vec_t;

    vec_t tbl[15];

    function automatic logic [8:0] ex(input logic b, d, w, a, input logic [1:0] c, input logic l, r);
        return {b, d, w, a, a, c, l, r};
    endfunction

    function automatic vec_t mk(input logic st, wl, dm, input logic [1:0] sh, input logic [15:0] words,
                                input logic wv, av, input logic [15:0] full, input logic idle, input logic [8:0] e);
        vec_t v;
        v.st = st; v.wl = wl; v.dm = dm; v.sh = sh; v.words = words;
        v.wv = wv; v.av = av; v.full = full; v.idle = idle; v.exp = e;
        return v;
    endfunction

    // compare outputs mid-cycle, then advance to 1 time unit after the next edge
    task automatic step(input string nm, input logic [8:0] e);
        #3;
        nvec++;
        if (outs !== e) begin
            nerr++;
            $display("FAIL %s: got {busy,done,wrd,ard,push,cas,lrs,wreg}=%b want %b", nm, outs, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] e);
        nvec++;
        if (act !== e) begin
            nerr++;
            $display("FAIL %s: got %0d want %0d", nm, act, e);
        end
    endtask

    // wload_en=1, 4 words, shift 2; optional 3-cycle stall on row 7 after the 2nd beat
    task automatic job(input logic dm, input logic stall);
        logic [1:0] c;
        logic l, r, s;
        c = dm ? 2'd0 : 2'd2;
        l = !dm;
        r = !dm;
        cfg_wload_en = 1'b1; cfg_use_dummy = dm; cfg_row_shift = 2'd2; cfg_num_act_words = 16'd4;
        wbuff_valid = 1'b1; actbuff_valid = 1'b1; pe_afifo_full = '0; pe_array_idle = 1'b0;
        start = 1'b1;
        step("job_idle", ex(0, 0, 0, 0, 2'd0, 0, 0));
        start = 1'b0;
        for (int i = 0; i < 16; i++) step("job_wload", ex(1, 0, 1, 0, 2'd0, 0, r));
        for (int i = 0; i < (stall ? 7 : 4); i++) begin
            s = stall && (i >= 2) && (i <= 4);
            pe_afifo_full = s ? 16'h0080 : 16'h0000;
            step(s ? "job_stall" : "job_beat", ex(1, 0, 0, !s, c, l, r));
        end
        pe_afifo_full = '0;
        step("job_drain", ex(1, 0, 0, 0, c, l, r));
        pe_array_idle = 1'b1;
        step("job_drain_idle", ex(1, 0, 0, 0, c, l, r));
        step("job_done", ex(1, 1, 0, 0, 2'd0, 0, r));
        pe_array_idle = 1'b0;
        step("job_back_idle", ex(0, 0, 0, 0, 2'd0, 0, 0));
        step("job_stay_idle", ex(0, 0, 0, 0, 2'd0, 0, 0));
    endtask

    initial begin
        tbl[0]  = mk(0, 0, 0, 2'd0, 16'd0, 0, 0, 16'h0, 0, ex(0, 0, 0, 0, 2'd0, 0, 0));
        tbl[1]  = mk(1, 0, 0, 2'd3, 16'd0, 1, 1, 16'h0, 0, ex(0, 0, 0, 0, 2'd0, 0, 0));
        tbl[2]  = mk(0, 0, 0, 2'd3, 16'd0, 1, 1, 16'h0, 0, ex(1, 0, 0, 0, 2'd3, 1, 0));
        tbl[3]  = mk(0, 0, 0, 2'd3, 16'd0, 1, 1, 16'h0, 1, ex(1, 0, 0, 0, 2'd3, 1, 0));
        tbl[4]  = mk(0, 0, 0, 2'd3, 16'd0, 1, 1, 16'h0, 1, ex(1, 1, 0, 0, 2'd0, 0, 0));
        tbl[5]  = mk(0, 0, 0, 2'd3, 16'd0, 1, 1, 16'h0, 0, ex(0, 0, 0, 0, 2'd0, 0, 0));
        tbl[6]  = mk(1, 0, 0, 2'd0, 16'd2, 0, 0, 16'h0, 0, ex(0, 0, 0, 0, 2'd0, 0, 0));
        tbl[7]  = mk(0, 1, 1, 2'd3, 16'd0, 0, 0, 16'h0, 0, ex(1, 0, 0, 0, 2'd1, 1, 0));
        tbl[8]  = mk(0, 1, 1, 2'd3, 16'd0, 0, 1, 16'h8, 0, ex(1, 0, 0, 0, 2'd1, 1, 0));
        tbl[9]  = mk(1, 1, 1, 2'd3, 16'd0, 1, 1, 16'h0, 0, ex(1, 0, 0, 1, 2'd1, 1, 0));
        tbl[10] = mk(0, 0, 0, 2'd0, 16'd0, 0, 1, 16'h0, 0, ex(1, 0, 0, 1, 2'd1, 1, 0));
        tbl[11] = mk(0, 0, 0, 2'd0, 16'd0, 0, 1, 16'h0, 0, ex(1, 0, 0, 0, 2'd1, 1, 0));
        tbl[12] = mk(0, 0, 0, 2'd0, 16'd0, 0, 1, 16'h0, 1, ex(1, 0, 0, 0, 2'd1, 1, 0));
        tbl[13] = mk(0, 0, 0, 2'd0, 16'd0, 0, 1, 16'h0, 1, ex(1, 1, 0, 0, 2'd0, 0, 0));
        tbl[14] = mk(0, 0, 0, 2'd0, 16'd0, 0, 1, 16'h0, 0, ex(0, 0, 0, 0, 2'd0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 15; i++) begin
            start = tbl[i].st; cfg_wload_en = tbl[i].wl; cfg_use_dummy = tbl[i].dm;
            cfg_row_shift = tbl[i].sh; cfg_num_act_words = tbl[i].words;
            wbuff_valid = tbl[i].wv; actbuff_valid = tbl[i].av;
            pe_afifo_full = tbl[i].full; pe_array_idle = tbl[i].idle;
            step($sformatf("tbl%0d", i), tbl[i].exp);
        end
        start = 1'b0;
        job(1'b0, 1'b0);
        job(1'b0, 1'b1);
`ifdef PE_DATA_IN_CTRL_PERF_CNT_EN
        chk32("stall_cycles_after_stall", stall_cycles, 32'd3);
`endif
        cfg_wload_en = 1'b0; cfg_use_dummy = 1'b0; cfg_row_shift = 2'd1; cfg_num_act_words = 16'd4;
        wbuff_valid = 1'b1; actbuff_valid = 1'b1; pe_afifo_full = '0; pe_array_idle = 1'b1;
        start = 1'b1;
        step("ab_idle", ex(0, 0, 0, 0, 2'd0, 0, 0));
        start = 1'b0;
        step("ab_beat1", ex(1, 0, 0, 1, 2'd1, 1, 0));
        abort = 1'b1;
        step("ab_beat2", ex(1, 0, 0, 1, 2'd1, 1, 0));
        abort = 1'b0;
        for (int i = 0; i < 3; i++) step("ab_after", ex(0, 0, 0, 0, 2'd0, 0, 0));
        job(1'b0, 1'b0);
`ifdef PE_DATA_IN_CTRL_PERF_CNT_EN
        chk32("stall_cycles_cleared", stall_cycles, 32'd0);
`endif
        cfg_wload_en = 1'b1; cfg_use_dummy = 1'b0; cfg_row_shift = 2'd2; cfg_num_act_words = 16'd4;
        pe_array_idle = 1'b0;
        start = 1'b1;
        step("rst_idle", ex(0, 0, 0, 0, 2'd0, 0, 0));
        start = 1'b0;
        for (int i = 0; i < 3; i++) step("rst_wload", ex(1, 0, 1, 0, 2'd0, 0, 1));
        rst_n = 1'b0;
        start = 1'b1;
        step("rst_edge", ex(1, 0, 1, 0, 2'd0, 0, 1));
        step("rst_held", ex(0, 0, 0, 0, 2'd0, 0, 0));
        rst_n = 1'b1;
        start = 1'b0;
        step("rst_release", ex(0, 0, 0, 0, 2'd0, 0, 0));
        step("rst_quiet", ex(0, 0, 0, 0, 2'd0, 0, 0));
        job(1'b1, 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
